// File: rtl/bus_transfer_sequencer.sv
// Sequences single register-to-register moves over a shared tri-state bus.
// Optional turnaround cycle after each completed transfer: define BUS_TURNAROUND_EN.
module bus_transfer_sequencer #(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned SEL_W    = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                bus_sequencer_clock,
   input  logic                bus_sequencer_reset,
   input  logic                xfer_valid,
   output logic                xfer_ready,
   input  logic [SEL_W-1:0]    xfer_src,
   input  logic [SEL_W-1:0]    xfer_dst,
   output logic [NUM_REGS-1:0] reg_out_en,
   output logic [NUM_REGS-1:0] reg_in_en,
   output logic                xfer_done,
   output logic                xfer_error,
   output logic [CNT_W-1:0]    xfer_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_LATCH,
      ST_DONE,
`ifdef BUS_TURNAROUND_EN
      ST_TURN,
`endif
      ST_ERR
   } state_t;

   state_t           state;
   logic [SEL_W-1:0] src_q;
   logic [SEL_W-1:0] dst_q;
   logic             src_bad_c;
   logic             dst_bad_c;

   assign src_bad_c = 32'(xfer_src) >= NUM_REGS;
   assign dst_bad_c = 32'(xfer_dst) >= NUM_REGS;

   function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
      return NUM_REGS'(1) << idx;
   endfunction

   // Outputs are set for the state being entered, so every output is a flop.
   always_ff @(posedge bus_sequencer_clock) begin
      if (bus_sequencer_reset) begin
         state      <= ST_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         xfer_ready <= 1'b1;
         reg_out_en <= '0;
         reg_in_en  <= '0;
         xfer_done  <= 1'b0;
         xfer_error <= 1'b0;
         xfer_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xfer_valid) begin
                  src_q      <= xfer_src;
                  dst_q      <= xfer_dst;
                  xfer_ready <= 1'b0;
                  if (src_bad_c || dst_bad_c) begin
                     state      <= ST_ERR;
                     xfer_error <= 1'b1;
                  end else if (xfer_src == xfer_dst) begin
                     state      <= ST_DONE;
                     xfer_done  <= 1'b1;
                     xfer_count <= xfer_count + CNT_W'(1);
                  end else begin
                     state      <= ST_DRIVE;
                     reg_out_en <= sel_onehot(xfer_src);
                  end
               end
            end
            ST_DRIVE: begin
               state     <= ST_LATCH;
               reg_in_en <= sel_onehot(dst_q);
            end
            ST_LATCH: begin
               state      <= ST_DONE;
               reg_out_en <= '0;
               reg_in_en  <= '0;
               xfer_done  <= 1'b1;
               xfer_count <= xfer_count + CNT_W'(1);
            end
            ST_DONE: begin
               xfer_done <= 1'b0;
`ifdef BUS_TURNAROUND_EN
               state     <= ST_TURN;
`else
               state      <= ST_IDLE;
               xfer_ready <= 1'b1;
`endif
            end
`ifdef BUS_TURNAROUND_EN
            ST_TURN: begin
               state      <= ST_IDLE;
               xfer_ready <= 1'b1;
            end
`endif
            ST_ERR: begin
               state      <= ST_IDLE;
               xfer_error <= 1'b0;
               xfer_ready <= 1'b1;
            end
            default: begin
               state      <= ST_IDLE;
               reg_out_en <= '0;
               reg_in_en  <= '0;
               xfer_done  <= 1'b0;
               xfer_error <= 1'b0;
               xfer_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench: a cycle-level transfer model predicts enables, ready and pulses.
module tb_bus_transfer_sequencer;

`ifdef BUS_TURNAROUND_EN
   localparam int TURN = 1;
`else
   localparam int TURN = 0;
`endif

   typedef struct {
      int          cycle;
      bit          is_err;
      bit          is_move;
      logic [15:0] cnt;
      int          dst;
      logic [15:0] data;
   } item_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [3:0]  src;
   logic [3:0]  dst;
   logic        ready1, done1, error1, ready2, done2, error2;
   logic [7:0]  out1, in1, out2, in2;
   logic [15:0] cnt1;
   logic [3:0]  cnt2;

   logic [15:0] bank [8];
   logic [7:0]  exp_out [int];
   logic [7:0]  exp_in [int];
   item_t       sb[$];
   int          cyc = 0;
   int          free = 0;
   int          acc_cnt = 0;
   logic [15:0] count_m = '0;
   int          n_vec = 0;
   int          n_mis = 0;

   always #5 clk = ~clk;

   bus_transfer_sequencer #(.NUM_REGS(8), .SEL_W(4), .CNT_W(16)) dut (
      .bus_sequencer_clock(clk), .bus_sequencer_reset(rst),
      .xfer_valid(valid), .xfer_ready(ready1), .xfer_src(src), .xfer_dst(dst),
      .reg_out_en(out1), .reg_in_en(in1), .xfer_done(done1), .xfer_error(error1),
      .xfer_count(cnt1));

   // Narrow counter instance exercises the wrap-around rule on the same stimulus.
   bus_transfer_sequencer #(.NUM_REGS(8), .SEL_W(4), .CNT_W(4)) dut_w4 (
      .bus_sequencer_clock(clk), .bus_sequencer_reset(rst),
      .xfer_valid(valid), .xfer_ready(ready2), .xfer_src(src), .xfer_dst(dst),
      .reg_out_en(out2), .reg_in_en(in2), .xfer_done(done2), .xfer_error(error2),
      .xfer_count(cnt2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model and register bank: cycle k is the period after the k-th edge.
   always @(posedge clk) begin
      item_t       it;
      logic [15:0] bv;
      if (rst) begin
         free    = cyc + 1;
         count_m = '0;
         exp_out.delete();
         exp_in.delete();
         while (sb.size() > 0 && sb[$].cycle > cyc) void'(sb.pop_back());
      end else if (valid && cyc >= free) begin
         it.dst = int'(dst); it.data = '0; it.is_move = 1'b0; it.is_err = 1'b0;
         if (src >= 4'd8 || dst >= 4'd8) begin
            it.is_err = 1'b1; it.cycle = cyc + 1; it.cnt = count_m;
            free = cyc + 2;
         end else if (src == dst) begin
            count_m++; it.cycle = cyc + 1; it.cnt = count_m;
            free = cyc + 2 + TURN;
         end else begin
            it.is_move = 1'b1; it.data = bank[src[2:0]];
            exp_out[cyc + 1] = 8'd1 << src;
            exp_out[cyc + 2] = 8'd1 << src;
            exp_in[cyc + 2]  = 8'd1 << dst;
            count_m++; it.cycle = cyc + 3; it.cnt = count_m;
            free = cyc + 4 + TURN;
         end
         sb.push_back(it);
         acc_cnt++;
      end
      if ($countones(out1) == 1) begin
         bv = '0;
         for (int i = 0; i < 8; i++) if (out1[i]) bv = bank[i];
         for (int i = 0; i < 8; i++) if (in1[i]) bank[i] = bv;
      end
      cyc++;
   end

   // Monitor: compares every cycle, pops the scoreboard on predicted pulse cycles.
   always @(negedge clk) begin
      logic [7:0] eo, ei;
      bit         exp_done, exp_err, hit;
      item_t      it;
      if (cyc > 0) begin
         eo = exp_out.exists(cyc) ? exp_out[cyc] : 8'h00;
         ei = exp_in.exists(cyc) ? exp_in[cyc] : 8'h00;
         hit = sb.size() > 0 && sb[0].cycle == cyc;
         exp_done = hit && !sb[0].is_err;
         exp_err  = hit && sb[0].is_err;
         check("ready", 32'(ready1), 32'(cyc >= free));
         check("out_en", 32'(out1), 32'(eo));
         check("in_en", 32'(in1), 32'(ei));
         check("done", 32'(done1), 32'(exp_done));
         check("error", 32'(error1), 32'(exp_err));
         check("single_driver", 32'($countones(out1) <= 1 && $countones(in1) <= 1), 32'd1);
         check("in_without_out", 32'(in1 != 0 && out1 == 0), 32'd0);
         check("w4_ready", 32'(ready2), 32'(cyc >= free));
         check("w4_out_en", 32'(out2), 32'(eo));
         check("w4_in_en", 32'(in2), 32'(ei));
         check("w4_done", 32'(done2), 32'(exp_done));
         check("w4_error", 32'(error2), 32'(exp_err));
         if (hit) begin
            it = sb.pop_front();
            check("count", 32'(cnt1), 32'(it.cnt));
            check("w4_count", 32'(cnt2), 32'(it.cnt[3:0]));
            if (it.is_move) check("moved_data", 32'(bank[it.dst]), 32'(it.data));
         end
         while (sb.size() > 0 && sb[0].cycle < cyc) begin
            void'(sb.pop_front());
            check("pulse_missing", 32'd0, 32'd1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int s, input int d, input bit hold);
      int start;
      int waited;
      start  = acc_cnt;
      waited = 0;
      valid  = 1'b1;
      src    = 4'(s);
      dst    = 4'(d);
      while (acc_cnt == start && waited < 20) begin
         step();
         waited++;
      end
      if (acc_cnt == start) check("accept_timeout", 32'd0, 32'd1);
      if (!hold) valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (sb.size() > 0 && waited < 30) begin
         step();
         waited++;
      end
      if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
      repeat (2) step();
   endtask

   initial begin
      for (int i = 0; i < 8; i++) bank[i] = 16'($urandom);
      bank[2] = 16'hA5C3;
      rst = 1'b1; valid = 1'b0; src = '0; dst = '0;
      repeat (2) step();
      check("reset_count", 32'(cnt1), 32'd0);
      check("reset_ready", 32'(ready1), 32'd1);
      check("reset_enables", 32'({out1, in1}), 32'd0);
      rst = 1'b0;
      step();

      issue(2, 5, 1'b0);
      drain();
      check("move_2_to_5", 32'(bank[5]), 32'h0000A5C3);
      check("count_after_move", 32'(cnt1), 32'd1);

      issue(9, 1, 1'b0);
      drain();
      check("count_after_error", 32'(cnt1), 32'd1);

      issue(3, 3, 1'b0);
      drain();
      check("count_after_noop", 32'(cnt1), 32'd2);

      issue(1, 4, 1'b1);
      issue(6, 0, 1'b1);
      issue(7, 2, 1'b0);
      drain();

      for (int k = 0; k < 16; k++) issue(k % 8, k % 8, k != 15);
      drain();

      for (int k = 0; k < 50; k++) begin
         bit h;
         h = 1'($urandom_range(0, 1));
         issue(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), h);
         if (!h) repeat ($urandom_range(0, 3)) step();
      end
      valid = 1'b0;
      drain();

      issue(0, 6, 1'b0);
      step();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      check("count_after_reset", 32'(cnt1), 32'd0);
      check("w4_count_after_reset", 32'(cnt2), 32'd0);
      repeat (3) step();

      issue(4, 7, 1'b0);
      drain();
      check("count_post_reset_move", 32'(cnt1), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
